iterative_divider: RTL and testbench



---
 rtl/iterative_divider.sv | 123 ++++++++++++
 tb/tb_iterative_divider.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_divider.sv
// Restoring unsigned divider: one quotient bit per clock, start/done handshake.
// Divide-by-zero completes immediately with an all-ones quotient and R = A.
module iterative_divider #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Start,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         Busy,
    output logic         Done,
    output logic         DivZero
);

    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [N-1:0]   wq, wq_n;
    logic [N-1:0]   wr, wr_n;
    logic [N-1:0]   d, d_n;
    logic [N-1:0]   q_n, r_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic           dz_n;
    logic [N:0]     wr_sh, trial;
    logic [N-1:0]   wq_step, wr_step;

    // One restoring step; a borrow out of the trial subtraction means keep the shifted remainder.
    always_comb begin
        wr_sh   = {wr, wq[N-1]};
        trial   = wr_sh - {1'b0, d};
        wq_step = {wq[N-2:0], ~trial[N]};
        wr_step = trial[N] ? wr_sh[N-1:0] : trial[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        wq_n    = wq;
        wr_n    = wr;
        d_n     = d;
        cnt_n   = cnt;
        q_n     = Q;
        r_n     = R;
        dz_n    = DivZero;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    wq_n  = A;
                    d_n   = B;
                    wr_n  = '0;
                    cnt_n = CW'(N);
                    if (B == '0) begin
                        state_n = DONE;
                        q_n     = '1;
                        r_n     = A;
                        dz_n    = 1'b1;
                    end else begin
                        state_n = RUN;
                        dz_n    = 1'b0;
                    end
                end
            end
            RUN: begin
                wq_n  = wq_step;
                wr_n  = wr_step;
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = DONE;
                    q_n     = wq_step;
                    r_n     = wr_step;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Datapath and output registers; results only update on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            wq      <= '0;
            wr      <= '0;
            d       <= '0;
            cnt     <= '0;
            Q       <= '0;
            R       <= '0;
            DivZero <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            wq      <= wq_n;
            wr      <= wr_n;
            d       <= d_n;
            cnt     <= cnt_n;
            Q       <= q_n;
            R       <= r_n;
            DivZero <= dz_n;
            Busy    <= (state_n != IDLE);
            Done    <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed and randomized checks of iterative_divider: results, latency, handshake, reset abort.
module tb_iterative_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        start;
    logic [31:0] q, r;
    logic        busy, done, div_zero;

    int pass_cnt = 0;
    int total    = 0;

    iterative_divider #(.N(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .A       (a),
        .B       (b),
        .Start   (start),
        .Q       (q),
        .R       (r),
        .Busy    (busy),
        .Done    (done),
        .DivZero (div_zero)
    );

    always #5 clk = ~clk;

    // Issue one division from IDLE; lat counts cycles from the Start edge to the Done cycle (40 = timeout).
    task automatic run_div(input logic [31:0] av, input logic [31:0] bv,
                           output int lat, output logic [31:0] qv,
                           output logic [31:0] rv, output logic dz);
        @(negedge clk);
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        qv = q;
        rv = r;
        dz = div_zero;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++; if (q !== 32'd0) $display("FAIL reset_q got %h exp 0", q); else pass_cnt++;
        total++; if (r !== 32'd0) $display("FAIL reset_r got %h exp 0", r); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
        total++; if (div_zero !== 1'b0) $display("FAIL reset_dz got %b exp 0", div_zero); else pass_cnt++;
    endtask

    task automatic test_basic();
        int lat;
        logic [31:0] qv, rv;
        logic dz;
        run_div(32'd75, 32'd25, lat, qv, rv, dz);
        total++; if (lat !== 33) $display("FAIL basic_lat got %0d exp 33", lat); else pass_cnt++;
        total++; if (qv !== 32'd3) $display("FAIL basic_q1 got %0d exp 3", qv); else pass_cnt++;
        total++; if (rv !== 32'd0) $display("FAIL basic_r1 got %0d exp 0", rv); else pass_cnt++;
        total++; if (dz !== 1'b0) $display("FAIL basic_dz1 got %b exp 0", dz); else pass_cnt++;
        total++; if (busy !== 1'b1) $display("FAIL busy_in_done got %b exp 1", busy); else pass_cnt++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL done_pulse_len got %b exp 0", done); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL busy_after got %b exp 0", busy); else pass_cnt++;
        run_div(32'd100, 32'd7, lat, qv, rv, dz);
        total++; if (qv !== 32'd14) $display("FAIL basic_q2 got %0d exp 14", qv); else pass_cnt++;
        total++; if (rv !== 32'd2) $display("FAIL basic_r2 got %0d exp 2", rv); else pass_cnt++;
    endtask

    task automatic test_boundary();
        logic [31:0] va [4] = '{32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] vb [4] = '{32'd1, 32'd10, 32'hFFFF_FFFF, 32'h8000_0001};
        logic [31:0] eq [4] = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0};
        logic [31:0] er [4] = '{32'd0, 32'd3, 32'd0, 32'h8000_0000};
        int lat;
        logic [31:0] qv, rv;
        logic dz;
        for (int i = 0; i < 4; i++) begin
            run_div(va[i], vb[i], lat, qv, rv, dz);
            total++;
            if (qv !== eq[i] || rv !== er[i] || lat !== 33)
                $display("FAIL boundary_%0d got q=%h r=%h lat=%0d exp q=%h r=%h lat=33",
                         i, qv, rv, lat, eq[i], er[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [31:0] qv, rv;
        logic dz;
        run_div(32'd5, 32'd0, lat, qv, rv, dz);
        total++; if (lat !== 1) $display("FAIL dz_lat got %0d exp 1", lat); else pass_cnt++;
        total++; if (qv !== 32'hFFFF_FFFF) $display("FAIL dz_q got %h exp ffffffff", qv); else pass_cnt++;
        total++; if (rv !== 32'd5) $display("FAIL dz_r got %0d exp 5", rv); else pass_cnt++;
        total++; if (dz !== 1'b1) $display("FAIL dz_flag got %b exp 1", dz); else pass_cnt++;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL dz_busy got %b exp 0", busy); else pass_cnt++;
        run_div(32'd9, 32'd2, lat, qv, rv, dz);
        total++;
        if (qv !== 32'd4 || rv !== 32'd1 || dz !== 1'b0)
            $display("FAIL dz_recover got q=%0d r=%0d dz=%b exp q=4 r=1 dz=0", qv, rv, dz);
        else pass_cnt++;
    endtask

    // Start held high; operands scrambled whenever the divider is busy.
    task automatic test_back_to_back();
        int done_cyc [$];
        @(negedge clk);
        a = 32'd50;
        b = 32'd6;
        start = 1'b1;
        for (int c = 1; c <= 101; c++) begin
            @(negedge clk);
            if (done) begin
                done_cyc.push_back(c);
                total++;
                if (q !== 32'd8 || r !== 32'd2)
                    $display("FAIL b2b_result got q=%0d r=%0d exp q=8 r=2", q, r);
                else pass_cnt++;
            end
            if (busy) begin
                a = $urandom;
                b = $urandom;
            end else begin
                a = 32'd50;
                b = 32'd6;
            end
        end
        start = 1'b0;
        total++;
        if (done_cyc.size() !== 3) $display("FAIL b2b_count got %0d exp 3", done_cyc.size());
        else pass_cnt++;
        for (int i = 1; i < done_cyc.size(); i++) begin
            total++;
            if (done_cyc[i] - done_cyc[i-1] !== 34)
                $display("FAIL b2b_period got %0d exp 34", done_cyc[i] - done_cyc[i-1]);
            else pass_cnt++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        int lat;
        logic [31:0] qv, rv;
        logic dz;
        @(negedge clk);
        a = 32'd75;
        b = 32'd25;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || q !== 32'd0 || r !== 32'd0)
            $display("FAIL midrst_state got busy=%b q=%h r=%h exp 0", busy, q, r);
        else pass_cnt++;
        repeat (40) begin
            if (done) seen++;
            @(negedge clk);
        end
        total++; if (seen !== 0) $display("FAIL midrst_nodone got %0d exp 0", seen); else pass_cnt++;
        run_div(32'd75, 32'd25, lat, qv, rv, dz);
        total++;
        if (qv !== 32'd3 || rv !== 32'd0 || lat !== 33)
            $display("FAIL midrst_after got q=%0d r=%0d lat=%0d exp 3 0 33", qv, rv, lat);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] qv, rv, av, bv, eq, er;
        logic dz, edz;
        int elat;
        for (int i = 0; i < 200; i++) begin
            av = $urandom;
            if (i % 20 == 0) bv = 32'd0;
            else if (i % 17 == 0) bv = 32'd1;
            else if (i % 3 == 0) bv = 32'($urandom_range(1, 255));
            else bv = $urandom;
            if (bv == 32'd0) begin
                eq = 32'hFFFF_FFFF; er = av; edz = 1'b1; elat = 1;
            end else begin
                eq = av / bv; er = av % bv; edz = 1'b0; elat = 33;
            end
            run_div(av, bv, lat, qv, rv, dz);
            total++;
            if (qv !== eq || rv !== er || dz !== edz || lat !== elat)
                $display("FAIL random_%0d a=%h b=%h got q=%h r=%h dz=%b lat=%0d exp q=%h r=%h dz=%b lat=%0d",
                         i, av, bv, qv, rv, dz, lat, eq, er, edz, elat);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
